// File: rtl/slime_ctrl_if.sv
// slime_ctrl_if: hero/attack inputs and slime status outputs of the slime controller
interface slime_ctrl_if;
   logic             level_start;
   logic             attack_valid;
   logic [9:0]       attack_row;
   logic [9:0]       attack_col;
   logic [9:0]       hero_row;
   logic [9:0]       hero_col;
   logic [2:0][9:0]  slim_row;
   logic [2:0][9:0]  slim_col;
   logic [2:0]       dead;
   logic             hero_hit;
   logic             all_dead;
   logic [1:0]       kill_count;
   modport master (
      output level_start, attack_valid, attack_row, attack_col, hero_row, hero_col,
      input  slim_row, slim_col, dead, hero_hit, all_dead, kill_count
   );
   modport slave (
      input  level_start, attack_valid, attack_row, attack_col, hero_row, hero_col,
      output slim_row, slim_col, dead, hero_hit, all_dead, kill_count
   );
endinterface

// File: rtl/slime_ctrl.sv
// slime_ctrl: per-frame patrol, hit/stun/death and contact logic for three slimes
module slime_ctrl #(
   parameter int MOVE_PERIOD = 8,
   parameter int HP_INIT     = 2,
   parameter int INVULN      = 4,
   parameter int COL_MIN     = 2,
   parameter int COL_MAX     = 37,
   parameter int ROW0        = 5,
   parameter int ROW1        = 12,
   parameter int ROW2        = 20,
   parameter int COL0        = 4,
   parameter int COL1        = 18,
   parameter int COL2        = 30
) (
   input logic         frame_clk,
   input logic         RESET_n,
   slime_ctrl_if.slave s
);
   localparam int CW = $clog2(MOVE_PERIOD);
   localparam int IW = $clog2(INVULN + 2);
   localparam logic [2:0][9:0] ROWS = {10'(ROW2), 10'(ROW1), 10'(ROW0)};
   localparam logic [2:0][9:0] COLS = {10'(COL2), 10'(COL1), 10'(COL0)};
   typedef enum logic [1:0] {ALIVE, STUNNED, DEAD} state_t;
   state_t               st_q [3];
   state_t               st_d [3];
   logic [2:0][9:0]      col_q, col_d;
   logic [2:0]           dir_q, dir_d;
   logic [2:0][1:0]      hp_q, hp_d;
   logic [2:0][IW-1:0]   inv_q, inv_d;
   logic [2:0]           dead_q, dead_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 hero_hit_q, hero_hit_d;
   logic                 all_dead_q, all_dead_d;
   logic [1:0]           kill_q, kill_d;
   logic                 tick;
   logic [2:0]           hit, step, flip;
   always_comb begin
      tick = cnt_q == CW'(MOVE_PERIOD - 1);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      hero_hit_d = 1'b0;
      hit = '0;
      step = '0;
      flip = '0;
      for (int k = 0; k < 3; k++) begin
         hit[k] = s.attack_valid && st_q[k] == ALIVE && ROWS[k] == s.attack_row && col_q[k] == s.attack_col;
         hero_hit_d = hero_hit_d | (st_q[k] != DEAD && ROWS[k] == s.hero_row && col_q[k] == s.hero_col);
         step[k] = tick && !hit[k] && st_q[k] != DEAD;
         flip[k] = dir_q[k] ? col_q[k] == 10'(COL_MAX) : col_q[k] == 10'(COL_MIN);
         // at a bound the step reverses heading and moves away in the same tick
         dir_d[k] = (step[k] && flip[k]) ? ~dir_q[k] : dir_q[k];
         col_d[k] = !step[k] ? col_q[k] : (dir_q[k] ^ flip[k]) ? col_q[k] + 10'd1 : col_q[k] - 10'd1;
         hp_d[k] = hit[k] ? hp_q[k] - 2'd1 : hp_q[k];
         inv_d[k] = hit[k] ? IW'(INVULN) : (inv_q[k] != '0) ? inv_q[k] - 1'b1 : inv_q[k];
         dead_d[k] = dead_q[k] | (hit[k] && hp_q[k] == 2'd1);
         st_d[k] = dead_d[k] ? DEAD : (inv_d[k] != '0) ? STUNNED : ALIVE;
      end
      if (s.level_start) begin
         cnt_d = '0;
         hero_hit_d = 1'b0;
         col_d = COLS;
         dir_d = '1;
         hp_d = {3{2'(HP_INIT)}};
         inv_d = '0;
         dead_d = '0;
         st_d = '{default: ALIVE};
      end
      kill_d = 2'(dead_d[0]) + 2'(dead_d[1]) + 2'(dead_d[2]);
      all_dead_d = &dead_d;
   end
   always_ff @(posedge frame_clk or negedge RESET_n) begin
      if (!RESET_n) begin
         cnt_q <= '0;
         col_q <= COLS;
         dir_q <= '1;
         hp_q <= {3{2'(HP_INIT)}};
         inv_q <= '0;
         dead_q <= '0;
         st_q <= '{default: ALIVE};
         hero_hit_q <= 1'b0;
         all_dead_q <= 1'b0;
         kill_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         col_q <= col_d;
         dir_q <= dir_d;
         hp_q <= hp_d;
         inv_q <= inv_d;
         dead_q <= dead_d;
         st_q <= st_d;
         hero_hit_q <= hero_hit_d;
         all_dead_q <= all_dead_d;
         kill_q <= kill_d;
      end
   end
   assign s.slim_row = ROWS;
   assign s.slim_col = col_q;
   assign s.dead = dead_q;
   assign s.hero_hit = hero_hit_q;
   assign s.all_dead = all_dead_q;
   assign s.kill_count = kill_q;
endmodule

// File: tb/tb_slime_ctrl.sv
// tb_slime_ctrl: randomized scoreboard bench for two slime_ctrl configurations
module tb_slime_ctrl;
   logic clk = 1'b0;
   logic RESET_n = 1'b0;
   always #5 clk = ~clk;
   slime_ctrl_if i0 ();
   slime_ctrl_if i1 ();
   slime_ctrl u0 (.frame_clk(clk), .RESET_n(RESET_n), .s(i0));
   // second instance: slimes 0 and 1 share a spawn tile, slime 2 spawns on the right bound
   slime_ctrl #(.HP_INIT(1), .ROW1(5), .COL0(10), .COL1(10), .COL2(37))
      u1 (.frame_clk(clk), .RESET_n(RESET_n), .s(i1));
   localparam int P_HP [2] = '{2, 1};
   localparam int ROWT [2][3] = '{'{5, 12, 20}, '{5, 5, 20}};
   localparam int COLT [2][3] = '{'{4, 18, 30}, '{10, 10, 37}};
   localparam int PERIOD = 8, INV = 4, CMIN = 2, CMAX = 37;
   typedef struct {
      int col [2][3];
      bit dead [2][3];
      bit hh [2];
   } exp_t;
   int m_col [2][3], m_dir [2][3], m_hp [2][3], m_inv [2][3], m_fr [2];
   bit m_dead [2][3];
   bit m_hh [2];
   exp_t q [$];
   int nerr = 0, nchk = 0;
   function automatic void m_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 3; k++) begin
            m_col[d][k] = COLT[d][k];
            m_dir[d][k] = 1;
            m_hp[d][k] = P_HP[d];
            m_inv[d][k] = 0;
            m_dead[d][k] = 0;
         end
         m_fr[d] = 0;
         m_hh[d] = 0;
      end
   endfunction
   function automatic void m_step(bit ls, bit av, int ar, int ac, int hr, int hc);
      bit tick, hit;
      if (ls) begin
         m_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         tick = (m_fr[d] % PERIOD) == PERIOD - 1;
         m_fr[d]++;
         m_hh[d] = 0;
         for (int k = 0; k < 3; k++)
            if (!m_dead[d][k] && ROWT[d][k] == hr && m_col[d][k] == hc) m_hh[d] = 1;
         for (int k = 0; k < 3; k++) begin
            if (m_dead[d][k]) continue;
            hit = av && m_inv[d][k] == 0 && ROWT[d][k] == ar && m_col[d][k] == ac;
            if (hit) begin
               if (m_hp[d][k] > 1) begin
                  m_hp[d][k]--;
                  m_inv[d][k] = INV;
               end else begin
                  m_hp[d][k] = 0;
                  m_dead[d][k] = 1;
               end
            end else begin
               if (m_inv[d][k] > 0) m_inv[d][k]--;
               if (tick) begin
                  if (m_dir[d][k] > 0 && m_col[d][k] >= CMAX) m_dir[d][k] = -1;
                  else if (m_dir[d][k] < 0 && m_col[d][k] <= CMIN) m_dir[d][k] = 1;
                  m_col[d][k] += m_dir[d][k];
               end
            end
         end
      end
   endfunction
   function automatic exp_t snap();
      exp_t e;
      e.col = m_col;
      e.dead = m_dead;
      e.hh = m_hh;
      return e;
   endfunction
   task automatic chk(string n, int act, int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endtask
   task automatic cmp(exp_t e);
      logic [2:0][9:0] o_col, o_row;
      logic [2:0] o_dead;
      logic o_hh, o_all;
      logic [1:0] o_kc;
      int kc;
      for (int d = 0; d < 2; d++) begin
         o_col = d == 0 ? i0.slim_col : i1.slim_col;
         o_row = d == 0 ? i0.slim_row : i1.slim_row;
         o_dead = d == 0 ? i0.dead : i1.dead;
         o_hh = d == 0 ? i0.hero_hit : i1.hero_hit;
         o_all = d == 0 ? i0.all_dead : i1.all_dead;
         o_kc = d == 0 ? i0.kill_count : i1.kill_count;
         kc = 0;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("col%0d_%0d", d, k), int'(o_col[k]), e.col[d][k]);
            chk($sformatf("row%0d_%0d", d, k), int'(o_row[k]), ROWT[d][k]);
            chk($sformatf("dead%0d_%0d", d, k), int'(o_dead[k]), int'(e.dead[d][k]));
            kc += int'(e.dead[d][k]);
         end
         chk($sformatf("hero_hit%0d", d), int'(o_hh), int'(e.hh[d]));
         chk($sformatf("kill_count%0d", d), int'(o_kc), kc);
         chk($sformatf("all_dead%0d", d), int'(o_all), int'(kc == 3));
      end
   endtask
   task automatic drive(bit ls, bit av, int ar, int ac, int hr, int hc);
      i0.level_start = ls;      i1.level_start = ls;
      i0.attack_valid = av;     i1.attack_valid = av;
      i0.attack_row = 10'(ar);  i1.attack_row = 10'(ar);
      i0.attack_col = 10'(ac);  i1.attack_col = 10'(ac);
      i0.hero_row = 10'(hr);    i1.hero_row = 10'(hr);
      i0.hero_col = 10'(hc);    i1.hero_col = 10'(hc);
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) cmp(q.pop_front());
   end
   initial begin
      int d, k, ar, ac, hr, hc;
      bit ls, av, stunned;
      drive(0, 0, 1023, 1023, 1023, 1023);
      m_reset();
      repeat (3) @(negedge clk);
      cmp(snap());
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 700 == 350) begin
            RESET_n = 1'b0;
            m_reset();
            #1 cmp(snap());
            q.push_back(snap());
            continue;
         end
         RESET_n = 1'b1;
         d = int'($urandom_range(0, 1));
         k = int'($urandom_range(0, 2));
         av = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 3) != 0) begin
            ar = ROWT[d][k];
            ac = m_col[d][k];
         end else begin
            ar = int'($urandom_range(0, 1023));
            ac = int'($urandom_range(0, 1023));
         end
         d = int'($urandom_range(0, 1));
         k = int'($urandom_range(0, 2));
         if ($urandom_range(0, 1) != 0) begin
            hr = ROWT[d][k];
            hc = m_col[d][k];
         end else begin
            hr = int'($urandom_range(0, 1023));
            hc = int'($urandom_range(0, 1023));
         end
         stunned = 0;
         for (int j = 0; j < 3; j++) if (m_inv[0][j] > 0) stunned = 1;
         ls = $urandom_range(0, 149) == 0 || (av && stunned && $urandom_range(0, 7) == 0);
         drive(ls, av, ar, ac, hr, hc);
         m_step(ls, av, ar, ac, hr, hc);
         q.push_back(snap());
      end
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/slime_ctrl.md
Name: slime_ctrl

Overview:
- Per-frame game-logic controller for the three slime enemies on the 16x16-pixel tile grid (40 cols x 30 rows).
- Moves each live slime on a horizontal patrol, resolves hero attacks into hit points, and flags death.
- Feeds tile positions and per-slime dead levels to the slime death-animation/sprite stage, which shifts tile coordinates left by 4 to get pixels.
- Also reports hero contact and wave-clear status to the game FSM.

Parameters:
- MOVE_PERIOD, 8: frames between patrol steps (>=2).
- HP_INIT, 2: hits needed to kill a slime (1..3).
- INVULN, 4: frames a slime ignores further hits after a non-lethal hit.
- COL_MIN, 2: leftmost patrol column.
- COL_MAX, 37: rightmost patrol column.
- ROW0/ROW1/ROW2, 5/12/20: fixed patrol row per slime.
- COL0/COL1/COL2, 4/18/30: spawn column per slime, within [COL_MIN, COL_MAX].

Ports:
- frame_clk  in  1  frame-rate clock; one edge per video frame.
- RESET_n  in  1  asynchronous, active-low reset.
- level_start  in  1  single-cycle synchronous re-initialise.
- attack_valid  in  1  single-cycle hero attack strobe.
- attack_row, attack_col  in  10 each  tile targeted by the attack.
- hero_row, hero_col  in  10 each  hero tile.
- slim_row[3], slim_col[3]  out  10 each  slime tile positions, registered.
- dead[3]  out  1 each  registered level; stays high until reset or level_start.
- hero_hit  out  1  registered; hero shares a tile with a live slime.
- all_dead  out  1  registered; all three slimes are dead.
- kill_count  out  2  number of dead slimes, 0..3.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (frame_clk, RESET_n).
- Reset and level_start state, identical values:
  - slim_row[k]=ROWk, slim_col[k]=COLk, direction=right.
  - hp[k]=HP_INIT, inv_cnt[k]=0, dead[k]=0, move counter=0.
  - hero_hit=0, all_dead=0, kill_count=0.
  - level_start overrides every other input in its cycle.
- Move tick:
  - The move counter counts 0..MOVE_PERIOD-1 and wraps.
  - tick=1 in the cycle where the counter equals MOVE_PERIOD-1.
  - On tick each live, unhit slime steps one column.
  - Heading right and col<COL_MAX: col+1. Heading right and col==COL_MAX: direction flips to left and col-1 in the same tick.
  - Heading left is the mirror, with COL_MIN as the bound.
  - Rows never change.
- Per-slime state machine ALIVE -> STUNNED -> ALIVE, any -> DEAD:
  - A hit is attack_valid && slim_row==attack_row && slim_col==attack_col. Positions are compared before this cycle's move.
  - A hit counts only in ALIVE, i.e. inv_cnt==0.
  - Hit with hp>1: hp-1, inv_cnt=INVULN, state STUNNED. The slime does not move on that cycle even if tick.
  - STUNNED: inv_cnt decrements each cycle. The slime still moves on ticks. Returns to ALIVE when inv_cnt reaches 0. Attacks are ignored while STUNNED.
  - Hit with hp==1: hp=0, dead=1 on the next edge, state DEAD.
  - DEAD: position frozen so the death animation plays in place; ignores attacks and ticks; excluded from contact.
- Simultaneous events:
  - One attack on a tile shared by several live slimes hits all of them in the same cycle.
  - Several slimes dying in the same cycle each raise dead and update kill_count together.
- Registered status outputs, updated every cycle:
  - hero_hit = OR over live slimes of (slim_row==hero_row && slim_col==hero_col), using pre-move positions; latency 1.
  - kill_count = popcount(next dead).
  - all_dead = (kill_count next == 3).
  - Both change on the same edge as dead.
- Reset mid-patrol or mid-stun returns all state to the reset values immediately. No partial state survives.
- All comparisons are 10-bit unsigned. Out-of-grid attack/hero coordinates simply never match.

Test Plan:
- Reset release, MOVE_PERIOD=8, no inputs:
  - slime0 at (5,4) until its col becomes 5 on the edge ending cycle 8, then 6 at cycle 16.
  - dead=0, hero_hit=0.
- Bounce: spawn slime2 at col 37 heading right -> first tick gives col 36 with direction left; next tick gives col 35.
- Two hits, HP_INIT=2, INVULN=4, on slime1 at (12,18):
  - First hit -> hp=1, no move that cycle.
  - Second hit 2 cycles later is ignored.
  - Hit after inv_cnt reaches 0 -> dead[1]=1 next edge, kill_count=1, col frozen thereafter.
- Overlap: slime0 and slime1 both at (5,10) via parameters, HP_INIT=1, one attack at (5,10) -> dead[0]=dead[1]=1 on the same edge, kill_count=2, all_dead=0.
- Contact:
  - hero at slime2's tile -> hero_hit=1 one cycle later.
  - Kill slime2 -> hero_hit=0 the following cycle.
  - all_dead=1 once the third slime dies.
- level_start asserted with attack_valid in the same cycle while a slime is STUNNED -> all outputs return to reset values and the attack has no effect. RESET_n low mid-tick has the same result asynchronously.
